sorted_table_search: RTL

Downstream consumer of the insertion sorter. Captures the sorter's popped output, which arrives largest-first, into a non-increasing table of up to 2^AW−1 words. It answers lookup requests with a registered, multi-cycle binary search. Each search returns a hit flag and the lowest matching index; on a miss, the index is the insertion position.

---
 rtl/sorted_table_search.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sorted_table_search.sv
// Non-increasing lookup table fed by the insertion sorter's popped output.
// Lookups run a registered binary search that returns the lowest match or the insertion position.
module sorted_table_search #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          clear,
  input  logic          wr,
  input  logic [DW-1:0] din,
  input  logic          find,
  input  logic [DW-1:0] key,
  output logic          full,
  output logic          empty,
  output logic          idle,
  output logic [AW-1:0] count,
  output logic          done,
  output logic          hit,
  output logic [AW-1:0] index,
  output logic          order_err
);

  localparam int unsigned Depth = (1 << AW) - 1;

  typedef enum logic [1:0] {StIdle, StMid, StCmp, StCheck} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   lo_q, lo_d, hi_q, hi_d, mid_q, mid_d;
  logic [AW+1:0] sum;
  logic [DW-1:0] key_q, key_d;
  logic [AW-1:0] count_q, count_d, index_q, index_d;
  logic          done_q, done_d, hit_q, hit_d, order_err_q, order_err_d;
  logic          mem_we;

  // Not reset: only entries below count_q are ever read meaningfully.
  logic [DW-1:0] mem [Depth];

  assign sum = {1'b0, lo_q} + {1'b0, hi_q};

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mid_d       = mid_q;
    key_d       = key_q;
    count_d     = count_q;
    index_d     = index_q;
    hit_d       = hit_q;
    order_err_d = order_err_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear) begin
          count_d     = '0;
          order_err_d = 1'b0;
        end else if (wr) begin
          if (count_q != AW'(Depth)) begin
            mem_we  = 1'b1;
            count_d = count_q + AW'(1);
            if (count_q != '0 && din > mem[count_q - AW'(1)]) order_err_d = 1'b1;
          end
        end else if (find) begin
          key_d   = key;
          lo_d    = '0;
          hi_d    = {1'b0, count_q};
          state_d = StMid;
        end
      end
      StMid: begin
        if (lo_q == hi_q) begin
          state_d = StCheck;
        end else begin
          mid_d   = sum[AW+1:1];
          state_d = StCmp;
        end
      end
      StCmp: begin
        // Entries greater than the key sit left of the answer.
        if (mem[mid_q[AW-1:0]] > key_q) lo_d = mid_q + (AW+1)'(1);
        else                            hi_d = mid_q;
        state_d = StMid;
      end
      StCheck: begin
        hit_d   = (lo_q < {1'b0, count_q}) && (mem[lo_q[AW-1:0]] == key_q);
        index_d = lo_q[AW-1:0];
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lo_q        <= '0;
      hi_q        <= '0;
      mid_q       <= '0;
      key_q       <= '0;
      count_q     <= '0;
      index_q     <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      order_err_q <= 1'b0;
    end else if (enable) begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      mid_q       <= mid_d;
      key_q       <= key_d;
      count_q     <= count_d;
      index_q     <= index_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      order_err_q <= order_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && enable && mem_we) mem[count_q] <= din;
  end

  assign full      = (count_q == AW'(Depth));
  assign empty     = (count_q == '0);
  assign idle      = (state_q == StIdle);
  assign count     = count_q;
  assign done      = done_q;
  assign hit       = hit_q;
  assign index     = index_q;
  assign order_err = order_err_q;

endmodule
